// File: rtl/rv32_hart_scheduler_pkg.sv
// rtl/rv32_hart_scheduler_pkg.sv - shared rv32 hart types and the per-hart run/stall transition rule
package rv32_hart_scheduler_pkg;

    localparam int SCHED_NUM_HARTS = 8;

    typedef logic [$clog2(SCHED_NUM_HARTS)-1:0] rv32_hart_id_t;

    typedef enum logic [1:0] {
        HART_IDLE  = 2'b00,
        HART_RUN   = 2'b01,
        HART_STALL = 2'b10
    } hart_state_e;

    // stop overrides everything; a pulse that does not apply to the current state is a no-op,
    // and set beats clr so a hart with a fresh outstanding memory op stays stalled.
    function automatic hart_state_e next_hart_state(hart_state_e cur, logic start, logic stop,
                                                    logic set, logic clr);
        hart_state_e nxt;
        nxt = cur;
        if (stop) begin
            nxt = HART_IDLE;
        end else begin
            case (cur)
                HART_RUN:   if (set) nxt = HART_STALL;
                HART_STALL: if (clr && !set) nxt = HART_RUN;
                HART_IDLE:  if (start) nxt = HART_RUN;
                default:    nxt = HART_IDLE;
            endcase
        end
        return nxt;
    endfunction

endpackage

// File: rtl/rv32_hart_scheduler_if.sv
// rtl/rv32_hart_scheduler_if.sv - control, issue, flush and perf signals of the hart scheduler
interface rv32_hart_scheduler_if
    import rv32_hart_scheduler_pkg::*;
#(
    parameter int NUM_HARTS = SCHED_NUM_HARTS,
    parameter int HART_ID_W = $clog2(NUM_HARTS),
    parameter int CNT_W     = 32
);
    logic                   sched_halt;
    logic [NUM_HARTS-1:0]   hart_start;
    logic [NUM_HARTS-1:0]   hart_stop;
    logic [NUM_HARTS-1:0]   hart_stall_set;
    logic [NUM_HARTS-1:0]   hart_stall_clr;
    logic                   redirect_valid;
    logic [HART_ID_W-1:0]   redirect_hart;
    logic                   issue_valid;
    logic [HART_ID_W-1:0]   issue_hart;
    logic                   flush_valid;
    logic [HART_ID_W-1:0]   flush_hart;
    logic [2*NUM_HARTS-1:0] hart_state;
    logic [HART_ID_W-1:0]   perf_sel;
    logic [CNT_W-1:0]       perf_cnt;

    modport master (
        output sched_halt, hart_start, hart_stop, hart_stall_set, hart_stall_clr,
        output redirect_valid, redirect_hart, perf_sel,
        input  issue_valid, issue_hart, flush_valid, flush_hart, hart_state, perf_cnt
    );

    modport slave (
        input  sched_halt, hart_start, hart_stop, hart_stall_set, hart_stall_clr,
        input  redirect_valid, redirect_hart, perf_sel,
        output issue_valid, issue_hart, flush_valid, flush_hart, hart_state, perf_cnt
    );

endinterface

// File: rtl/rv32_hart_scheduler_rr_picker.sv
// rtl/rv32_hart_scheduler_rr_picker.sv - rv32_rr_picker: first set bit of mask after ptr, wrapping
module rv32_rr_picker
    import rv32_hart_scheduler_pkg::*;
#(
    parameter int NUM_HARTS = SCHED_NUM_HARTS,
    parameter int HART_ID_W = $clog2(NUM_HARTS)
) (
    input  logic [NUM_HARTS-1:0] mask,
    input  logic [HART_ID_W-1:0] ptr,
    output logic                 found,
    output logic [HART_ID_W-1:0] id
);
    localparam logic [HART_ID_W-1:0] LAST_HART = HART_ID_W'(NUM_HARTS - 1);

    logic [HART_ID_W-1:0] idx;

    // Walk NUM_HARTS positions starting just after ptr; the pointer itself is visited last.
    always_comb begin
        found = 1'b0;
        id    = '0;
        idx   = ptr;
        for (int i = 0; i < NUM_HARTS; i++) begin
            idx = (idx == LAST_HART) ? '0 : idx + HART_ID_W'(1);
            if (!found && mask[idx]) begin
                found = 1'b1;
                id    = idx;
            end
        end
    end

endmodule

// File: rtl/rv32_hart_scheduler.sv
// rtl/rv32_hart_scheduler.sv - barrel-core issue scheduler; RV32_SCHED_PERF_EN adds per-hart issue counters
module rv32_hart_scheduler
    import rv32_hart_scheduler_pkg::*;
#(
    parameter int NUM_HARTS  = SCHED_NUM_HARTS,
    parameter int HART_ID_W  = $clog2(NUM_HARTS),
    parameter int PIPE_DEPTH = 4,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    rv32_hart_scheduler_if.slave  bus
);
    localparam int                   CD_W      = (PIPE_DEPTH > 1) ? $clog2(PIPE_DEPTH) : 1;
    localparam logic [CD_W-1:0]      CD_RELOAD = CD_W'(PIPE_DEPTH - 1);
    localparam logic [HART_ID_W-1:0] LAST_HART = HART_ID_W'(NUM_HARTS - 1);

    hart_state_e          state_q [NUM_HARTS];
    hart_state_e          state_d [NUM_HARTS];
    logic [CD_W-1:0]      cool_q  [NUM_HARTS];
    logic [CD_W-1:0]      cool_d  [NUM_HARTS];
    logic [NUM_HARTS-1:0] eligible;
    logic [NUM_HARTS-1:0] redirect_hit;
    logic [HART_ID_W-1:0] rr_ptr_q;
    logic [HART_ID_W-1:0] pick_id;
    logic                 pick_found;
    logic                 do_issue;
    logic                 issue_valid_q;
    logic [HART_ID_W-1:0] issue_hart_q;
    logic                 flush_valid_q;
    logic [HART_ID_W-1:0] flush_hart_q;

    // A hart with a same-cycle stop, stall or redirect must not be picked this cycle.
    always_comb begin
        eligible     = '0;
        redirect_hit = '0;
        for (int h = 0; h < NUM_HARTS; h++) begin
            redirect_hit[h] = bus.redirect_valid && (bus.redirect_hart == HART_ID_W'(h));
            eligible[h]     = (state_q[h] == HART_RUN) && (cool_q[h] == '0) &&
                              !bus.hart_stall_set[h] && !bus.hart_stop[h] && !redirect_hit[h];
        end
    end

    rv32_rr_picker #(
        .NUM_HARTS (NUM_HARTS),
        .HART_ID_W (HART_ID_W)
    ) u_picker (
        .mask  (eligible),
        .ptr   (rr_ptr_q),
        .found (pick_found),
        .id    (pick_id)
    );

    assign do_issue = pick_found && !bus.sched_halt;

    always_comb begin
        for (int h = 0; h < NUM_HARTS; h++) begin
            state_d[h] = next_hart_state(state_q[h], bus.hart_start[h], bus.hart_stop[h],
                                         bus.hart_stall_set[h], bus.hart_stall_clr[h]);
            cool_d[h]  = cool_q[h];
            if (bus.hart_stop[h]) begin
                cool_d[h] = '0;
            end else if ((do_issue && (pick_id == HART_ID_W'(h))) || redirect_hit[h]) begin
                cool_d[h] = CD_RELOAD;
            end else if (cool_q[h] != '0) begin
                cool_d[h] = cool_q[h] - CD_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int h = 0; h < NUM_HARTS; h++) begin
                state_q[h] <= HART_IDLE;
                cool_q[h]  <= '0;
            end
            rr_ptr_q      <= LAST_HART;
            issue_valid_q <= 1'b0;
            issue_hart_q  <= '0;
            flush_valid_q <= 1'b0;
            flush_hart_q  <= '0;
        end else begin
            for (int h = 0; h < NUM_HARTS; h++) begin
                state_q[h] <= state_d[h];
                cool_q[h]  <= cool_d[h];
            end
            issue_valid_q <= do_issue;
            if (do_issue) begin
                issue_hart_q <= pick_id;
                rr_ptr_q     <= pick_id;
            end
            flush_valid_q <= bus.redirect_valid;
            if (bus.redirect_valid) begin
                flush_hart_q <= bus.redirect_hart;
            end
        end
    end

    assign bus.issue_valid = issue_valid_q;
    assign bus.issue_hart  = issue_hart_q;
    assign bus.flush_valid = flush_valid_q;
    assign bus.flush_hart  = flush_hart_q;

    always_comb begin
        bus.hart_state = '0;
        for (int h = 0; h < NUM_HARTS; h++) begin
            bus.hart_state[2*h +: 2] = state_q[h];
        end
    end

`ifdef RV32_SCHED_PERF_EN
    logic [CNT_W-1:0] perf_q [NUM_HARTS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int h = 0; h < NUM_HARTS; h++) begin
                perf_q[h] <= '0;
            end
        end else begin
            for (int h = 0; h < NUM_HARTS; h++) begin
                if (do_issue && (pick_id == HART_ID_W'(h))) begin
                    perf_q[h] <= perf_q[h] + CNT_W'(1);
                end
            end
        end
    end

    // Selects with no matching hart fall through to zero.
    always_comb begin
        bus.perf_cnt = '0;
        for (int h = 0; h < NUM_HARTS; h++) begin
            if (bus.perf_sel == HART_ID_W'(h)) begin
                bus.perf_cnt = perf_q[h];
            end
        end
    end
`else
    logic unused_perf_sel;
    assign unused_perf_sel = ^bus.perf_sel;
    assign bus.perf_cnt    = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_rv32_hart_scheduler.sv
// tb/tb_rv32_hart_scheduler.sv - bench for rv32_hart_scheduler against a cycle-level reference model
module tb_rv32_hart_scheduler;
    localparam int N   = 8;
    localparam int PD  = 4;
    localparam int IDW = 3;
    localparam int CW  = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rv32_hart_scheduler_if #(.NUM_HARTS(N), .HART_ID_W(IDW), .CNT_W(CW)) bus ();

    rv32_hart_scheduler #(
        .NUM_HARTS (N),
        .HART_ID_W (IDW),
        .PIPE_DEPTH(PD),
        .CNT_W     (CW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    logic [N-1:0]   g_start, g_stop, g_set, g_clr;
    logic           g_halt, g_rv, g_rst;
    logic [IDW-1:0] g_rh, g_sel;

    // model: state 0 idle / 1 run / 2 stall; m_blk = decision cycle of last issue or redirect
    int          m_st  [N];
    longint      m_blk [N];
    logic [31:0] m_cnt [N];
    int          m_ptr;
    longint      m_n;
    int          exp_iv, exp_ih, exp_fv, exp_fh;

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        for (int h = 0; h < N; h++) begin
            m_st[h]  = 0;
            m_blk[h] = -1000;
            m_cnt[h] = '0;
        end
        m_ptr  = N - 1;
        m_n    = 0;
        exp_iv = 0; exp_ih = 0; exp_fv = 0; exp_fh = 0;
    endtask

    task automatic model_step();
        int pick;
        int h;
        pick = -1;
        for (int k = 1; k <= N; k++) begin
            h = (m_ptr + k) % N;
            if (pick < 0 && m_st[h] == 1 && (m_n - m_blk[h]) >= PD && !g_set[h] && !g_stop[h]
                && !(g_rv && g_rh == h))
                pick = h;
        end
        if (pick >= 0 && !g_halt) begin
            exp_iv = 1; exp_ih = pick; m_ptr = pick;
            m_blk[pick] = m_n;
            m_cnt[pick] = m_cnt[pick] + 1;
        end else begin
            exp_iv = 0;
        end
        exp_fv = g_rv;
        if (g_rv) begin
            exp_fh = g_rh;
            m_blk[g_rh] = m_n;
        end
        for (int j = 0; j < N; j++) begin
            if (g_stop[j]) begin
                m_st[j] = 0; m_blk[j] = -1000;
            end else if (m_st[j] == 1 && g_set[j]) m_st[j] = 2;
            else if (m_st[j] == 2 && g_clr[j] && !g_set[j]) m_st[j] = 1;
            else if (m_st[j] == 0 && g_start[j]) m_st[j] = 1;
        end
        m_n++;
    endtask

    function automatic logic [31:0] exp_state_vec();
        logic [31:0] v;
        v = '0;
        for (int h = 0; h < N; h++) v[2*h +: 2] = 2'(m_st[h]);
        return v;
    endfunction

    function automatic logic [31:0] exp_perf(logic [IDW-1:0] sel);
`ifdef RV32_SCHED_PERF_EN
        return m_cnt[sel];
`else
        return (sel == sel) ? 32'd0 : 32'd1;
`endif
    endfunction

    task automatic tick();
        @(negedge clk);
        rst                = g_rst;
        bus.hart_start     = g_start;
        bus.hart_stop      = g_stop;
        bus.hart_stall_set = g_set;
        bus.hart_stall_clr = g_clr;
        bus.sched_halt     = g_halt;
        bus.redirect_valid = g_rv;
        bus.redirect_hart  = g_rh;
        bus.perf_sel       = g_sel;
        if (g_rst) model_reset();
        else       model_step();
        g_start = '0; g_stop = '0; g_set = '0; g_clr = '0; g_rv = 1'b0;
    endtask

    task automatic sync();
        @(posedge clk);
        #2;
    endtask

    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            chk("issue_valid", 32'(bus.issue_valid), exp_iv);
            chk("issue_hart",  32'(bus.issue_hart),  exp_ih);
            chk("flush_valid", 32'(bus.flush_valid), exp_fv);
            chk("flush_hart",  32'(bus.flush_hart),  exp_fh);
            chk("hart_state",  32'(bus.hart_state),  exp_state_vec());
            chk("perf_cnt",    bus.perf_cnt,         exp_perf(bus.perf_sel));
        end
    end

    initial begin
        int seen;
        int last;
        rst = 1'b1;
        g_start = '0; g_stop = '0; g_set = '0; g_clr = '0;
        g_halt = 1'b0; g_rv = 1'b0; g_rh = '0; g_sel = '0; g_rst = 1'b1;
        bus.hart_start = '0; bus.hart_stop = '0; bus.hart_stall_set = '0; bus.hart_stall_clr = '0;
        bus.sched_halt = 1'b0; bus.redirect_valid = 1'b0; bus.redirect_hart = '0; bus.perf_sel = '0;
        model_reset();
        chk_en = 1'b1;

        tick(); tick();
        g_rst = 1'b0;
        tick(); tick();
        sync();
        chk("rst_state", 32'(bus.hart_state), 32'd0);
        chk("rst_issue", 32'(bus.issue_valid), 32'd0);
        chk("rst_flush", 32'(bus.flush_valid), 32'd0);

        // all harts start together: strict rotation from hart 0
        g_start = '1; tick();
        for (int i = 0; i < 9; i++) begin
            tick(); sync();
            chk("rr_valid", 32'(bus.issue_valid), 32'd1);
            chk("rr_order", 32'(bus.issue_hart), i % 8);
        end

        // lone hart 3 issues every fourth cycle
        g_stop = '1; tick();
        g_start = 8'h08; tick();
        for (int i = 0; i < 9; i++) begin
            tick(); sync();
            chk("lone_valid", 32'(bus.issue_valid), (i % 4 == 0) ? 32'd1 : 32'd0);
            if (i % 4 == 0) chk("lone_hart", 32'(bus.issue_hart), 32'd3);
        end

        // stall hart 1 while hart 0 keeps running
        g_stop = 8'h08; g_start = 8'h03; tick();
        repeat (4) tick();
        g_set = 8'h02; tick();
        for (int i = 0; i < 12; i++) begin
            tick(); sync();
            chk("stall_skip", 32'(bus.issue_valid && bus.issue_hart == 3'd1), 32'd0);
        end
        g_clr = 8'h02; tick();
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            tick(); sync();
            if (bus.issue_valid && bus.issue_hart == 3'd1) seen = 1;
        end
        chk("stall_resume", seen, 32'd1);
        g_set = 8'h02; tick();
        g_set = 8'h02; g_clr = 8'h02; tick(); sync();
        chk("set_clr_stall", 32'(bus.hart_state[3:2]), 32'd2);

        // redirect hart 5 with all harts running, then halt
        g_start = '1; g_clr = '1; tick();
        repeat (10) tick();
        g_rv = 1'b1; g_rh = 3'd5; tick(); sync();
        chk("redir_flush", 32'(bus.flush_valid), 32'd1);
        chk("redir_hart", 32'(bus.flush_hart), 32'd5);
        chk("redir_skip", 32'(bus.issue_valid && bus.issue_hart == 3'd5), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick(); sync();
            chk("redir_skip", 32'(bus.issue_valid && bus.issue_hart == 3'd5), 32'd0);
        end
        last = exp_ih;
        g_halt = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(); sync();
            chk("halt_idle", 32'(bus.issue_valid), 32'd0);
        end
        g_halt = 1'b0; tick(); sync();
        chk("halt_resume_v", 32'(bus.issue_valid), 32'd1);
        chk("halt_resume_h", 32'(bus.issue_hart), (last + 1) % 8);

        // randomized traffic including occasional mid-run resets
        for (int i = 0; i < 2000; i++) begin
            g_start = N'($urandom & $urandom);
            g_stop  = ($urandom_range(0, 15) == 0) ? N'(1) << $urandom_range(0, N - 1) : '0;
            g_set   = ($urandom_range(0, 5) == 0) ? N'(1) << $urandom_range(0, N - 1) : '0;
            g_clr   = N'($urandom & $urandom);
            if ($urandom_range(0, 9) == 0) g_halt = ~g_halt;
            g_rv    = ($urandom_range(0, 5) == 0);
            g_rh    = IDW'($urandom_range(0, N - 1));
            g_sel   = IDW'($urandom_range(0, N - 1));
            g_rst   = ($urandom_range(0, 299) == 0);
            tick();
            g_rst = 1'b0;
        end
        g_halt = 1'b0;

        // fresh counters, 80 issue cycles over 8 harts
        g_rst = 1'b1; tick(); tick();
        g_rst = 1'b0; tick();
        g_start = '1; tick();
        repeat (80) tick();
        g_stop = '1; tick();
        for (int i = 0; i < 8; i++) begin
            g_sel = IDW'(i); tick(); sync();
`ifdef RV32_SCHED_PERF_EN
            chk("perf_ten", bus.perf_cnt, 32'd10);
`else
            chk("perf_zero", bus.perf_cnt, 32'd0);
`endif
        end

        tick();
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
